// File: rtl/mm2x2_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mm2x2_sequencer
// Description : Sequencing controller for a 2x2 signed 2-bit matrix multiply.
//               Captures packed A/B operand bytes on start, then walks the
//               four dot products through one shared 2x2-bit signed
//               multiplier and a 5-bit accumulator. Each finished C element
//               is streamed out over a valid/ready handshake.
// Ports       : clk      - rising-edge clock
//               rst_n    - asynchronous active-low reset
//               ena      - design select; low freezes all state
//               start    - request a new job (sampled in IDLE only)
//               a_in     - A packed {a00,a01,a10,a11}, 2-bit signed each
//               b_in     - B packed {b00,b01,b10,b11}, 2-bit signed each
//               c_ready  - downstream accepts current element
//               c_valid  - c_data/c_idx hold a finished element
//               c_data   - signed C element (-4..8)
//               c_idx    - element index 0=c00 1=c01 2=c10 3=c11
//               busy     - high in every state except IDLE
//               done     - one-cycle pulse after the c11 handshake
// Revision    : 1.0 - initial release
// ============================================================================
module mm2x2_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       c_ready,
  output logic       c_valid,
  output logic [4:0] c_data,
  output logic [1:0] c_idx,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL0 = 2'd1;
  localparam logic [1:0] c_MUL1 = 2'd2;
  localparam logic [1:0] c_EMIT = 2'd3;

  logic [1:0] r_state;
  logic [1:0] r_k;
  logic [4:0] r_acc;
  logic [7:0] r_opA;
  logic [7:0] r_opB;
  logic [4:0] r_cData;
  logic [1:0] r_cIdx;
  logic       r_donePend;

  logic       w_inner;
  logic [1:0] w_mulA;
  logic [1:0] w_mulB;
  logic [3:0] w_prod;
  logic [4:0] w_prodExt;
  logic [4:0] w_sum;

  // Selects element n (row-major index {row,col}) from a packed 2x2 byte.
  function automatic logic [1:0] pickElem(input logic [7:0] m, input logic [1:0] n);
    logic [1:0] e;
    case (n)
      2'd0:    e = m[7:6];
      2'd1:    e = m[5:4];
      2'd2:    e = m[3:2];
      default: e = m[1:0];
    endcase
    return e;
  endfunction

  // Inner-product index: MUL0 uses a_i0*b_0j, MUL1 uses a_i1*b_1j.
  assign w_inner = (r_state == c_MUL1);
  assign w_mulA  = pickElem(r_opA, {r_k[1], w_inner});
  assign w_mulB  = pickElem(r_opB, {w_inner, r_k[0]});

  // Single shared multiplier; operands sign-extended to 4 bits so the
  // 4-bit signed product covers the full -2..4 range without overflow.
  assign w_prod    = 4'($signed({{2{w_mulA[1]}}, w_mulA}) * $signed({{2{w_mulB[1]}}, w_mulB}));
  assign w_prodExt = {w_prod[3], w_prod};
  assign w_sum     = r_acc + w_prodExt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_k        <= 2'd0;
      r_acc      <= 5'd0;
      r_opA      <= 8'd0;
      r_opB      <= 8'd0;
      r_cData    <= 5'd0;
      r_cIdx     <= 2'd0;
      r_donePend <= 1'b0;
    end else if (ena) begin
      // done lives for exactly one enabled cycle.
      r_donePend <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_opA   <= a_in;
            r_opB   <= b_in;
            r_k     <= 2'd0;
            r_acc   <= 5'd0;
            r_state <= c_MUL0;
          end
        end
        c_MUL0: begin
          r_acc   <= w_prodExt;
          r_state <= c_MUL1;
        end
        c_MUL1: begin
          // Output registers are loaded only here so c_data/c_idx stay
          // stable through EMIT and hold their last value elsewhere.
          r_acc   <= w_sum;
          r_cData <= w_sum;
          r_cIdx  <= r_k;
          r_state <= c_EMIT;
        end
        c_EMIT: begin
          if (c_ready) begin
            if (r_k == 2'd3) begin
              r_state    <= c_IDLE;
              r_donePend <= 1'b1;
            end else begin
              r_k     <= r_k + 2'd1;
              r_state <= c_MUL0;
            end
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign c_valid = (r_state == c_EMIT);
  assign c_data  = r_cData;
  assign c_idx   = r_cIdx;
  assign busy    = (r_state != c_IDLE);
  // A pending done waits out an ena=0 stretch and fires on the next enabled cycle.
  assign done    = r_donePend & ena;

endmodule
`default_nettype wire
